// File: rtl/gate_pkg.sv
// gate_pkg: shared sizing helpers, FSM state constants and the fixed-point
// round/saturate and hard-activation functions used by gate_stream.
package gate_pkg;

  // Widest accumulator / result the helper functions operate on.
  localparam int MAX_ACC_W = 128;
  localparam int MAX_Y_W   = 64;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_X  = 3'd1;
  localparam logic [2:0] S_RD_Y  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_ACT   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  function automatic int f_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // Full product width plus enough guard bits for every term and the bias.
  function automatic int f_acc_w(input int bw, input int ncols);
    return 2 * bw + $clog2(ncols + 1);
  endfunction

  function automatic int f_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half up at the QM boundary, then clamp to the bw-bit signed range.
  function automatic logic signed [MAX_Y_W-1:0] round_sat(
    input  logic signed [MAX_ACC_W-1:0] acc,
    input  int                          bw,
    input  int                          qm,
    output logic                        ovf
  );
    logic signed [MAX_ACC_W-1:0] t, maxv, minv;
    t = acc;
    if (qm > 0) t = (acc + (128'sd1 <<< (qm - 1))) >>> qm;
    maxv = (128'sd1 <<< (bw - 1)) - 128'sd1;
    minv = -(128'sd1 <<< (bw - 1));
    ovf  = 1'b0;
    if (t > maxv) begin
      t   = maxv;
      ovf = 1'b1;
    end else if (t < minv) begin
      t   = minv;
      ovf = 1'b1;
    end
    return $signed(t[MAX_Y_W-1:0]);
  endfunction

  // Hard sigmoid: clamp(y/4 + 0.5, 0, 1). Hard tanh: clamp(y, -1, 1).
  function automatic logic signed [MAX_Y_W-1:0] hard_act(
    input logic signed [MAX_Y_W-1:0] y,
    input logic                      tanh_sel,
    input int                        qm
  );
    logic signed [MAX_Y_W-1:0] one, v;
    one = 64'sd1 <<< qm;
    if (tanh_sel) begin
      v = y;
      if (v > one) v = one;
      else if (v < -one) v = -one;
    end else begin
      v = (y >>> 2) + (one >>> 1);
      if (v < 64'sd0) v = 64'sd0;
      else if (v > one) v = one;
    end
    return v;
  endfunction

endpackage

// File: rtl/gate_mac_lane.sv
// gate_mac_lane: one row of the gate. Holds the wide accumulator.
//   i_load   : acc <= bias << QM (start of run)
//   i_mac_en : acc += i_w * i_v (full signed product)
//   o_y/o_ovf: combinational round/saturate of the current accumulator
module gate_mac_lane
  import gate_pkg::*;
#(
  parameter int BW    = 18,
  parameter int ACC_W = 41,
  parameter int QM    = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_mac_en,
  input  logic signed [BW-1:0] i_bias,
  input  logic signed [BW-1:0] i_w,
  input  logic signed [BW-1:0] i_v,
  output logic signed [BW-1:0] o_y,
  output logic                 o_ovf
);

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [2*BW-1:0]      w_prod;
  logic signed [MAX_ACC_W-1:0] w_acc_ext;
  logic signed [MAX_Y_W-1:0]   w_sat_wide;
  logic                        w_ovf;
  logic                        w_unused_hi;

  assign w_prod    = i_w * i_v;
  assign w_acc_ext = {{(MAX_ACC_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= {{(ACC_W-BW){i_bias[BW-1]}}, i_bias} <<< QM;
    end else if (i_mac_en) begin
      r_acc <= r_acc + {{(ACC_W-2*BW){w_prod[2*BW-1]}}, w_prod};
    end
  end

  always_comb begin
    w_ovf      = 1'b0;
    w_sat_wide = round_sat(w_acc_ext, BW, QM, w_ovf);
    o_y        = w_sat_wide[BW-1:0];
    o_ovf      = w_ovf;
  end

  // Result is already clamped to BW bits; upper bits are redundant sign.
  assign w_unused_hi = ^w_sat_wide[MAX_Y_W-1:BW];

endmodule

// File: rtl/gate_stream.sv
// gate_stream: streaming LSTM gate pre-activation
//   gateOutput[r] = sum Wx[r][c]*x[c] + sum Wy[r][c]*h[c] + b[r]
// One weight column per cycle feeds HIDDEN_SZ row lanes (X columns then Y).
// Optional macro GATE_ACT_EN adds a hard sigmoid/tanh stage (ACT_TANH).
// Ports:
//   clock, reset (async active low)
//   beginCalc/skipRecurrent : start request, sampled in IDLE
//   colAddress_X/Y, rdEn_X/Y: column read requests (data returns 1 cycle later)
//   weightMem_X/Y, inputVec, prevLayerOut : read return data
//   biasVec                 : sampled when a run is accepted
//   busy, dataReady_gate, gateOutput, overflowFlag : status and result
module gate_stream
  import gate_pkg::*;
#(
  parameter  int INPUT_SZ  = 8,
  parameter  int HIDDEN_SZ = 16,
  parameter  int QN        = 6,
  parameter  int QM        = 11,
  parameter  int ACT_TANH  = 0,
  localparam int BW        = f_bitwidth(QN, QM),
  localparam int ACC_W     = f_acc_w(BW, INPUT_SZ + HIDDEN_SZ),
  localparam int AW_X      = f_addr_w(INPUT_SZ),
  localparam int AW_Y      = f_addr_w(HIDDEN_SZ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    beginCalc,
  input  logic                    skipRecurrent,
  output logic [AW_X-1:0]         colAddress_X,
  output logic [AW_Y-1:0]         colAddress_Y,
  output logic                    rdEn_X,
  output logic                    rdEn_Y,
  input  logic [BW*HIDDEN_SZ-1:0] weightMem_X,
  input  logic [BW*HIDDEN_SZ-1:0] weightMem_Y,
  input  logic [BW-1:0]           inputVec,
  input  logic [BW-1:0]           prevLayerOut,
  input  logic [BW*HIDDEN_SZ-1:0] biasVec,
  output logic                    busy,
  output logic                    dataReady_gate,
  output logic [BW*HIDDEN_SZ-1:0] gateOutput,
  output logic                    overflowFlag
);

  localparam logic [AW_X-1:0] LAST_X = AW_X'(INPUT_SZ - 1);
  localparam logic [AW_Y-1:0] LAST_Y = AW_Y'(HIDDEN_SZ - 1);

  logic [2:0]                       r_state;
  logic [AW_X-1:0]                  r_cnt_x;
  logic [AW_Y-1:0]                  r_cnt_y;
  logic                             r_skip;
  logic                             r_rd_vld;   // a read return is on the data inputs
  logic                             r_rd_vld_y; // ...and it belongs to the Y phase
  logic [HIDDEN_SZ-1:0][BW-1:0]     r_gate;
  logic                             r_ovf_out;

  logic                             w_accept;
  logic [BW*HIDDEN_SZ-1:0]          w_w;
  logic [BW-1:0]                    w_v;
  logic [HIDDEN_SZ-1:0][BW-1:0]     w_y;
  logic [HIDDEN_SZ-1:0]             w_ovf;

  assign w_accept       = (r_state == S_IDLE) && beginCalc;
  assign rdEn_X         = (r_state == S_RD_X);
  assign rdEn_Y         = (r_state == S_RD_Y);
  assign colAddress_X   = rdEn_X ? r_cnt_x : '0;
  assign colAddress_Y   = rdEn_Y ? r_cnt_y : '0;
  assign busy           = (r_state != S_IDLE);
  assign dataReady_gate = (r_state == S_DONE);
  assign gateOutput     = r_gate;
  assign overflowFlag   = r_ovf_out;

  assign w_w = r_rd_vld_y ? weightMem_Y  : weightMem_X;
  assign w_v = r_rd_vld_y ? prevLayerOut : inputVec;

  for (genvar r = 0; r < HIDDEN_SZ; r++) begin : g_lane
    gate_mac_lane #(.BW(BW), .ACC_W(ACC_W), .QM(QM)) u_lane (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_accept),
      .i_mac_en (r_rd_vld),
      .i_bias   (biasVec[r*BW +: BW]),
      .i_w      (w_w[r*BW +: BW]),
      .i_v      (w_v),
      .o_y      (w_y[r]),
      .o_ovf    (w_ovf[r])
    );
  end

`ifdef GATE_ACT_EN
  logic [HIDDEN_SZ-1:0][BW-1:0] r_y;
  logic                         r_ovf;
  logic [HIDDEN_SZ-1:0][BW-1:0] w_act;
  logic signed [MAX_Y_W-1:0]    w_act_wide [HIDDEN_SZ];
  logic                         w_unused_act_hi;

  always_comb begin
    w_unused_act_hi = 1'b0;
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      w_act_wide[r]   = hard_act({{(MAX_Y_W-BW){r_y[r][BW-1]}}, r_y[r]},
                                 ACT_TANH != 0, QM);
      w_act[r]        = w_act_wide[r][BW-1:0];
      w_unused_act_hi = w_unused_act_hi ^ (^w_act_wide[r][MAX_Y_W-1:BW]);
    end
  end
`else
  logic w_unused_act;
  assign w_unused_act = (ACT_TANH != 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt_x    <= '0;
      r_cnt_y    <= '0;
      r_skip     <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_vld_y <= 1'b0;
      r_gate     <= '0;
      r_ovf_out  <= 1'b0;
`ifdef GATE_ACT_EN
      r_y        <= '0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_rd_vld   <= rdEn_X | rdEn_Y;
      r_rd_vld_y <= rdEn_Y;
      case (r_state)
        S_IDLE: if (beginCalc) begin
          r_state <= S_RD_X;
          r_cnt_x <= '0;
          r_skip  <= skipRecurrent;
        end
        S_RD_X: if (r_cnt_x == LAST_X) begin
          r_cnt_y <= '0;
          r_state <= r_skip ? S_DRAIN : S_RD_Y;
        end else begin
          r_cnt_x <= r_cnt_x + AW_X'(1);
        end
        S_RD_Y: if (r_cnt_y == LAST_Y) begin
          r_state <= S_DRAIN;
        end else begin
          r_cnt_y <= r_cnt_y + AW_Y'(1);
        end
        // Last column's data arrives here; lanes absorb it on this edge.
        S_DRAIN: r_state <= S_ROUND;
`ifdef GATE_ACT_EN
        S_ROUND: begin
          r_y     <= w_y;
          r_ovf   <= |w_ovf;
          r_state <= S_ACT;
        end
        S_ACT: begin
          r_gate    <= w_act;
          r_ovf_out <= r_ovf;
          r_state   <= S_DONE;
        end
`else
        S_ROUND: begin
          r_gate    <= w_y;
          r_ovf_out <= |w_ovf;
          r_state   <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_stream.sv
module tb_gate_stream;
  localparam int I  = 2;
  localparam int H  = 2;
  localparam int BW = 18;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              beginCalc = 1'b0;
  logic              skipRecurrent = 1'b0;
  logic [0:0]        colAddress_X, colAddress_Y;
  logic              rdEn_X, rdEn_Y;
  logic [BW*H-1:0]   weightMem_X = '0, weightMem_Y = '0;
  logic [BW-1:0]     inputVec = '0, prevLayerOut = '0;
  logic [BW*H-1:0]   biasVec = '0;
  logic              busy, dataReady_gate, overflowFlag;
  logic [BW*H-1:0]   gateOutput;

  gate_stream #(.INPUT_SZ(I), .HIDDEN_SZ(H), .QN(6), .QM(11), .ACT_TANH(0)) dut (
    .clock(clock), .reset(reset), .beginCalc(beginCalc), .skipRecurrent(skipRecurrent),
    .colAddress_X(colAddress_X), .colAddress_Y(colAddress_Y),
    .rdEn_X(rdEn_X), .rdEn_Y(rdEn_Y),
    .weightMem_X(weightMem_X), .weightMem_Y(weightMem_Y),
    .inputVec(inputVec), .prevLayerOut(prevLayerOut), .biasVec(biasVec),
    .busy(busy), .dataReady_gate(dataReady_gate),
    .gateOutput(gateOutput), .overflowFlag(overflowFlag)
  );

  always #5 clock = ~clock;

  // Memory model: one-cycle read latency.
  logic signed [BW-1:0] wx [H][I];
  logic signed [BW-1:0] wy [H][H];
  logic signed [BW-1:0] xv [I];
  logic signed [BW-1:0] hv [H];
  int ny_total = 0, ndone = 0, addr_bad = 0;

  always @(posedge clock) begin
    if (rdEn_X) begin
      for (int r = 0; r < H; r++) weightMem_X[r*BW +: BW] <= wx[r][colAddress_X];
      inputVec <= xv[colAddress_X];
    end
    if (rdEn_Y) begin
      for (int r = 0; r < H; r++) weightMem_Y[r*BW +: BW] <= wy[r][colAddress_Y];
      prevLayerOut <= hv[colAddress_Y];
      ny_total <= ny_total + 1;
    end
    if (dataReady_gate) ndone <= ndone + 1;
  end

  always @(negedge clock)
    if (reset && ((!rdEn_X && colAddress_X != 0) || (!rdEn_Y && colAddress_Y != 0)))
      addr_bad <= addr_bad + 1;

  typedef struct {
    logic skip;
    int wx, wy, x0, x1, h0, h1, b0, b1;
    int e0, e1, ovf, lat;
  } vec_t;

  vec_t vt [8];
  int nchk = 0, nerr = 0;

  task automatic chk(input string name, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int lane(input int r);
    logic [BW-1:0] v;
    v = gateOutput[r*BW +: BW];
    return int'($signed(v));
  endfunction

  task automatic load(input vec_t v);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < I; c++) wx[r][c] = 18'(v.wx);
      for (int c = 0; c < H; c++) wy[r][c] = 18'(v.wy);
    end
    xv[0] = 18'(v.x0); xv[1] = 18'(v.x1);
    hv[0] = 18'(v.h0); hv[1] = 18'(v.h1);
    biasVec = {18'(v.b1), 18'(v.b0)};
  endtask

  // Starts a run and returns cycles from the accept edge to dataReady (-1 on timeout).
  task automatic do_run(input logic skip, output int lat);
    lat = -1;
    @(negedge clock);
    beginCalc = 1'b1;
    skipRecurrent = skip;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      beginCalc = 1'b0;
      if (n == 2) chk("busy_mid", int'(busy), 1);
      if (dataReady_gate) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, ny0, nd0, k2;
    vt[0] = '{1'b0, 2048, 2048, 2048, 2048, 1024, 1024, 512, 512, 6656, 6656, 0, 7};
    vt[1] = '{1'b1, 2048, 2048, 2048, 2048, 1024, 1024, 512, 512, 4608, 4608, 0, 5};
    vt[2] = '{1'b0, 65536, 0, 65536, 65536, 0, 0, 0, 0, 131071, 131071, 1, 7};
    vt[3] = '{1'b0, -65536, 0, 65536, 65536, 0, 0, 0, 0, -131072, -131072, 1, 7};
    vt[4] = '{1'b0, 1, 0, 1024, 0, 0, 0, 0, -3, 1, -2, 0, 7};
    vt[5] = '{1'b0, -1, 0, 1024, 0, 0, 0, 0, 5, 0, 5, 0, 7};
    vt[6] = '{1'b0, 1024, -2048, 4096, -2048, 2048, 1024, 0, 1024, -2048, -1024, 0, 7};
    vt[7] = '{1'b1, 0, 0, 0, 0, 0, 0, 131071, -131072, 131071, -131072, 0, 5};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(dataReady_gate), 0);
    chk("rst_rden", int'({rdEn_X, rdEn_Y}), 0);
    chk("rst_out", int'(gateOutput != 0), 0);
    chk("rst_ovf", int'(overflowFlag), 0);
    reset = 1'b1;

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      load(vt[i]);
      ny0 = ny_total;
      do_run(vt[i].skip, lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_lane0", i), lane(0), vt[i].e0);
      chk($sformatf("v%0d_lane1", i), lane(1), vt[i].e1);
      chk($sformatf("v%0d_ovf", i), int'(overflowFlag), vt[i].ovf);
      @(negedge clock);
      chk($sformatf("v%0d_pulse1", i), int'(dataReady_gate), 0);
      chk($sformatf("v%0d_rdY", i), ny_total - ny0, vt[i].skip ? 0 : H);
    end

    // Reset mid-run: outputs cleared, no completion follows
    load(vt[0]);
    @(negedge clock);
    beginCalc = 1'b1; skipRecurrent = 1'b0;
    @(negedge clock);
    beginCalc = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_out", int'(gateOutput != 0), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rden", int'({rdEn_X, rdEn_Y}), 0);
    @(negedge clock);
    reset = 1'b1;
    nd0 = ndone;
    repeat (12) @(negedge clock);
    chk("mid_rst_nodone", ndone - nd0, 0);

    // beginCalc re-pulsed while busy: single completion, same result
    nd0 = ndone;
    @(negedge clock);
    beginCalc = 1'b1;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      beginCalc = (n == 2 || n == 4) ? 1'b1 : 1'b0;
      if (dataReady_gate) begin
        lat = n;
        break;
      end
    end
    chk("rep_lat", lat, 7);
    chk("rep_lane0", lane(0), 6656);
    chk("rep_lane1", lane(1), 6656);
    repeat (12) @(negedge clock);
    chk("rep_single", ndone - nd0, 1);

    // beginCalc during DONE is ignored; accepted on the following IDLE cycle
    do_run(1'b0, lat);
    chk("b2b_first", lat, 7);
    beginCalc = 1'b1;
    k2 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 2) beginCalc = 1'b0;
      if (dataReady_gate) begin
        k2 = k;
        break;
      end
    end
    chk("b2b_second", k2, 8);
    chk("b2b_lane0", lane(0), 6656);

    @(negedge clock);
    chk("addr_zero_idle", addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
